instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Parametrised instruction memory with a word-streaming loader and a registered fetch port for the MIPS core. The loader runs a valid/ready handshake. It writes a burst of words starting at a base word address, with auto-increment and wrap-around. The fetch port takes byte addresses from the PC, returns data one cycle later, and flags misaligned fetches. Fetch is locked out while a load burst is in progress.

Parameters:
ADDR_W, 10, word-address width; depth = 2**ADDR_W words
DATA_W, 32, instruction word width
FILL_WORD, 32'h0000_0000, value returned on a rejected or misaligned fetch (MIPS nop)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
load_start  in  1  one-cycle pulse; begins a burst (accepted only in IDLE)
load_base  in  ADDR_W  first word address of the burst, sampled with load_start
load_count  in  ADDR_W+1  number of words in the burst, sampled with load_start; 0..2**ADDR_W
ld_valid  in  1  loader data valid
ld_data  in  DATA_W  loader data word
ld_ready  out  1  memory can accept ld_data this cycle
load_busy  out  1  high in LOAD state
load_done  out  1  one-cycle pulse when a burst completes
fetch_en  in  1  fetch request this cycle
fetch_addr  in  ADDR_W+2  byte address; bits [1:0] must be 00
fetch_data  out  DATA_W  instruction word, registered
fetch_valid  out  1  fetch_data holds a good word for the previous cycle's request
fetch_misalign  out  1  registered; previous request had fetch_addr[1:0] != 0
fetch_perr  out  1  registered parity error flag (see Optional Feature)

Behaviour:
- Reset values (asynchronous, while rst=1):
  - state=IDLE; ld_ready=0, load_busy=0, load_done=0
  - fetch_valid=0, fetch_misalign=0, fetch_perr=0, fetch_data=FILL_WORD
  - write pointer and remaining count cleared
  - memory array contents are NOT cleared
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - load_start=1 with load_count=0 -> DONE; no writes.
  - load_start=1 with load_count>0 -> LOAD; ptr<=load_base, remaining<=load_count.
- LOAD:
  - ld_ready=1 and load_busy=1.
  - On ld_valid&&ld_ready: mem[ptr]<=ld_data, ptr<=ptr+1 (wraps modulo 2**ADDR_W), remaining<=remaining-1.
  - When the accepted word makes remaining reach 0 -> DONE.
  - ld_valid=0 stalls indefinitely with no state change.
  - load_start is ignored in LOAD and DONE.
- DONE: load_done=1 for exactly one cycle -> IDLE. ld_ready=0.
- Burst with load_count=2**ADDR_W starting at base B writes every location once; the final ptr equals B again.
- Fetch, one-cycle latency. On the edge where fetch_en=1:
  - state==LOAD: fetch_valid<=0, fetch_data<=FILL_WORD (locked out).
  - fetch_addr[1:0]!=0: fetch_misalign<=1, fetch_valid<=0, fetch_data<=FILL_WORD.
  - otherwise: fetch_data<=mem[fetch_addr[ADDR_W+1:2]], fetch_valid<=1, fetch_misalign<=0.
- fetch_en=0: fetch_valid<=0, fetch_misalign<=0; fetch_data holds its last value.
- Fetch in IDLE or DONE is allowed. A fetch on the same edge as the last LOAD write is locked out, because state is still LOAD.
- Reset mid-burst: FSM returns to IDLE at once. Words already written stay in memory. No load_done pulse.
- The read is synchronous, so the array must map to block RAM: one write port (loader) and one read port (fetch).

Optional Feature:
IMEM_PARITY_EN
- Defined:
  - each stored word carries an extra even-parity bit, computed from ld_data on write
  - on a good fetch, parity is recomputed over the read word; fetch_perr<=1 on mismatch, else 0
  - fetch_valid is still asserted on a parity error; the core decides what to do
- Undefined: no parity storage; fetch_perr is held at 0.

Test Plan:
- Reset, then load_start with base=5, count=2, data 3AFEBABE, FACEFEED (ld_valid held high) -> two accepted words, load_done pulses on the cycle after the 2nd word; fetch_addr=0x014 -> next cycle fetch_data=3AFEBABE, fetch_valid=1; fetch_addr=0x018 -> FACEFEED.
- Burst base=1022, count=4, data 11111111..44444444 -> words at 1022,1023,0,1; fetch 0x000 -> 33333333, fetch 0xFFC -> 22222222.
- ld_valid toggled 1,0,0,1,1 during a count=3 burst -> exactly 3 writes, load_busy high throughout, load_done one cycle after the 3rd accept; load_count=0 -> load_done on the cycle after load_start, memory unchanged.
- fetch_en with fetch_addr=0x016 -> fetch_misalign=1, fetch_valid=0, fetch_data=00000000; fetch_en during LOAD -> fetch_valid=0.
- Assert rst after 1 of 3 words written at base 40 (data ABCD0001) -> outputs at reset values immediately; after release, fetch 0x0A0 -> ABCD0001, word 41 unchanged.
- With IMEM_PARITY_EN: force a bit flip in a stored word via hierarchical force -> fetch_perr=1 and fetch_valid=1 on that fetch; clean word -> fetch_perr=0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction memory: burst loader (valid/ready, wrapping pointer) plus a registered fetch port; IMEM_PARITY_EN adds a parity bit per word.
// Fetch latency 1 cycle, locked out while loading; the loader stalls indefinitely on ld_valid=0 and accepts words only in LOAD.
module instr_mem_loader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter logic [DATA_W-1:0] FILL_WORD = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W:0]   load_count,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              load_busy,
   output logic              load_done,
   input  logic              fetch_en,
   input  logic [ADDR_W+1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_valid,
   output logic              fetch_misalign,
   output logic              fetch_perr
);

   localparam int DEPTH = 2 ** ADDR_W;
`ifdef IMEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W:0]   REM_ONE = 1;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic              valid_q, valid_d;
   logic              mis_q, mis_d;
   logic              src_q, src_d;
   logic              wr_en, rd_en;
   logic [MEM_W-1:0]  wr_word;
   logic [MEM_W-1:0]  rd_word_q;
   logic [ADDR_W-1:0] fetch_idx;

   logic [MEM_W-1:0]  mem [0:DEPTH-1];

   assign fetch_idx = fetch_addr[ADDR_W+1:2];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               if (load_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD;
                  ptr_d   = load_base;
                  rem_d   = load_count;
               end
            end
         end
         S_LOAD: begin
            if (ld_valid) begin
               wr_en = 1'b1;
               ptr_d = ptr_q + PTR_ONE;
               rem_d = rem_q - REM_ONE;
               if (rem_q == REM_ONE) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // src_q selects the RAM output register vs. FILL_WORD, so a reject or reset
   // shows the fill value while fetch_en=0 simply holds whatever was shown.
   always_comb begin
      valid_d = 1'b0;
      mis_d   = 1'b0;
      src_d   = src_q;
      rd_en   = 1'b0;
      if (fetch_en) begin
         if (state_q == S_LOAD) begin
            src_d = 1'b0;
         end else if (fetch_addr[1:0] != 2'b00) begin
            mis_d = 1'b1;
            src_d = 1'b0;
         end else begin
            rd_en   = 1'b1;
            valid_d = 1'b1;
            src_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
         src_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
         src_q   <= src_d;
      end
   end

`ifdef IMEM_PARITY_EN
   assign wr_word = {^ld_data, ld_data};
`else
   assign wr_word = ld_data;
`endif

   // No reset here so the array and its output register map onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[ptr_q] <= wr_word;
      if (rd_en) rd_word_q <= mem[fetch_idx];
   end

   assign ld_ready       = (state_q == S_LOAD);
   assign load_busy      = (state_q == S_LOAD);
   assign load_done      = (state_q == S_DONE);
   assign fetch_valid    = valid_q;
   assign fetch_misalign = mis_q;
   assign fetch_data     = src_q ? rd_word_q[DATA_W-1:0] : FILL_WORD;

`ifdef IMEM_PARITY_EN
   assign fetch_perr = valid_q & (^rd_word_q);
`else
   assign fetch_perr = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: randomized and directed traffic against a word-array reference model.
module tb_instr_mem_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_start = 1'b0;
   logic [9:0]  load_base = '0;
   logic [10:0] load_count = '0;
   logic        ld_valid = 1'b0;
   logic [31:0] ld_data = '0;
   logic        ld_ready, load_busy, load_done;
   logic        fetch_en = 1'b0;
   logic [11:0] fetch_addr = '0;
   logic [31:0] fetch_data;
   logic        fetch_valid, fetch_misalign, fetch_perr;

   localparam logic [31:0] FILL = 32'h0000_0000;

   instr_mem_loader dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
      .load_count(load_count), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .load_busy(load_busy), .load_done(load_done),
      .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
      .fetch_valid(fetch_valid), .fetch_misalign(fetch_misalign), .fetch_perr(fetch_perr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v, m, p, busy, done;
      logic [31:0] d;
      bit          chk_d;
   } exp_t;

   exp_t        q[$];
   int          tests = 0;
   int          fails = 0;

   // Reference model: words in memory and where the burst stands
   logic [31:0] model_mem [1024];
   bit          written [1024];
   int          m_phase = 0;      // 0 idle, 1 burst in progress, 2 completion cycle
   int          m_ptr = 0;
   int          m_rem = 0;
   logic [31:0] last_d = FILL;
   bit          last_known = 1'b1;
   bit          perr_next = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!rst && q.size() > 0) begin
         e = q.pop_front();
         chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.v});
         chk("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, e.m});
         chk("fetch_perr", {31'b0, fetch_perr}, {31'b0, e.p});
         chk("load_busy", {31'b0, load_busy}, {31'b0, e.busy});
         chk("ld_ready", {31'b0, ld_ready}, {31'b0, e.busy});
         chk("load_done", {31'b0, load_done}, {31'b0, e.done});
         if (e.chk_d) chk("fetch_data", fetch_data, e.d);
      end
   end

   // One clock of stimulus; called at a negedge, returns at the next negedge.
   task automatic cyc(input bit fe, input logic [11:0] fa, input bit lv, input logic [31:0] ld,
                      input bit ls, input logic [9:0] lb, input logic [10:0] lc);
      exp_t e;
      int   idx;
      fetch_en = fe; fetch_addr = fa; ld_valid = lv; ld_data = ld;
      load_start = ls; load_base = lb; load_count = lc;
      idx = int'(fa[11:2]);
      e.v = 1'b0; e.m = 1'b0; e.p = 1'b0;
      if (!fe) begin
         e.d = last_d; e.chk_d = last_known;
      end else if (m_phase == 1) begin
         e.d = FILL; e.chk_d = 1'b1;
      end else if (fa[1:0] != 2'b00) begin
         e.m = 1'b1; e.d = FILL; e.chk_d = 1'b1;
      end else begin
         e.v = 1'b1; e.d = model_mem[idx]; e.chk_d = written[idx];
         e.p = perr_next;
      end
      last_d = e.d; last_known = e.chk_d;
      perr_next = 1'b0;
      case (m_phase)
         0: if (ls) begin
               if (lc == 0) m_phase = 2;
               else begin m_phase = 1; m_ptr = int'(lb); m_rem = int'(lc); end
            end
         1: if (lv) begin
               model_mem[m_ptr] = ld; written[m_ptr] = 1'b1;
               m_ptr = (m_ptr + 1) % 1024;
               m_rem = m_rem - 1;
               if (m_rem == 0) m_phase = 2;
            end
         default: m_phase = 0;
      endcase
      e.busy = (m_phase == 1);
      e.done = (m_phase == 2);
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(0, 12'h0, 0, 32'h0, 0, 10'h0, 11'h0);
   endtask

   task automatic fetch(input logic [11:0] a);
      cyc(1, a, 0, 32'h0, 0, 10'h0, 11'h0);
   endtask

   task automatic start(input logic [9:0] b, input logic [10:0] c);
      cyc(0, 12'h0, 0, 32'h0, 1, b, c);
   endtask

   task automatic word(input logic [31:0] d);
      cyc(0, 12'h0, 1, d, 0, 10'h0, 11'h0);
   endtask

   task automatic check_reset_values();
      chk("rst_ld_ready", {31'b0, ld_ready}, 32'h0);
      chk("rst_load_busy", {31'b0, load_busy}, 32'h0);
      chk("rst_load_done", {31'b0, load_done}, 32'h0);
      chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
      chk("rst_fetch_misalign", {31'b0, fetch_misalign}, 32'h0);
      chk("rst_fetch_perr", {31'b0, fetch_perr}, 32'h0);
      chk("rst_fetch_data", fetch_data, FILL);
   endtask

   task automatic mid_reset();
      fetch_en = 0; ld_valid = 0; load_start = 0;
      rst = 1'b1;
      #1;
      check_reset_values();
      q.delete();
      m_phase = 0; last_d = FILL; last_known = 1'b1; perr_next = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int          base;
      int          cnt;
      int          idx;
      logic [11:0] fa;
      bit          fe;
      for (int i = 0; i < 1024; i++) begin model_mem[i] = '0; written[i] = 1'b0; end
      #3;
      check_reset_values();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // First burst; fetch during the burst is locked out
      start(10'd5, 11'd2);
      cyc(1, 12'h014, 1, 32'h3AFE_BABE, 0, 10'h0, 11'h0);
      word(32'hFACE_FEED);
      idle();
      fetch(12'h014);
      fetch(12'h018);
      idle();

      // Wrap-around; fetch on the edge of the last write is still locked
      start(10'd1022, 11'd4);
      word(32'h1111_1111); word(32'h2222_2222); word(32'h3333_3333);
      cyc(1, 12'h000, 1, 32'h4444_4444, 0, 10'h0, 11'h0);
      fetch(12'h000);
      fetch(12'hFFC);
      fetch(12'h004);

      // Stalling burst, then a zero-length burst
      start(10'd100, 11'd3);
      word(32'hA0A0_0001); idle(); idle(); word(32'hA0A0_0002); word(32'hA0A0_0003);
      idle();
      start(10'd5, 11'd0);
      idle();
      fetch(12'h014); fetch(12'h190); fetch(12'h198);

      // Misaligned fetch, then hold with fetch_en low
      fetch(12'h016);
      idle();
      fetch(12'h018);
      idle(); idle();

      // Reset in the middle of a burst
      start(10'd41, 11'd1);
      word(32'h5A5A_5A5A);
      idle(); idle();
      start(10'd40, 11'd3);
      word(32'hABCD_0001);
      mid_reset();
      fetch(12'h0A0);
      fetch(12'h0A4);
      idle();

`ifdef IMEM_PARITY_EN
      start(10'd50, 11'd2);
      word(32'h1234_5678); word(32'h0F0F_0F0F);
      idle();
      dut.mem[50] = dut.mem[50] ^ 33'h1;
      model_mem[50] = model_mem[50] ^ 32'h1;
      perr_next = 1'b1;
      fetch(12'h0C8);
      fetch(12'h0CC);
      idle();
`endif

      // Full-depth burst with random stalls and locked-out fetches
      base = int'($urandom_range(0, 1023));
      start(base[9:0], 11'd1024);
      for (int k = 0; k < 3000 && m_phase != 0; k++) begin
         fe = ($urandom_range(0, 7) == 0);
         cyc(fe, 12'h0, ($urandom_range(0, 3) != 0), $urandom, 0, 10'h0, 11'h0);
      end
      for (int k = -2; k < 3; k++) begin
         idx = (base + k + 1024) % 1024;
         fa = {idx[9:0], 2'b00};
         fetch(fa);
      end

      // Randomized bursts interleaved with fetches
      for (int b = 0; b < 25; b++) begin
         base = int'($urandom_range(0, 1023));
         cnt  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 8));
         start(base[9:0], cnt[10:0]);
         for (int k = 0; k < 200 && m_phase != 0; k++) begin
            idx = (base + int'($urandom_range(0, 9))) % 1024;
            fa = {idx[9:0], 2'b00};
            if ($urandom_range(0, 3) == 0) fa[1:0] = 2'($urandom_range(1, 3));
            cyc($urandom_range(0, 1) == 1, fa, $urandom_range(0, 1) == 1, $urandom,
                $urandom_range(0, 3) == 0, 10'($urandom), 11'($urandom_range(0, 8)));
         end
         for (int k = 0; k < 6; k++) begin
            idx = (base + int'($urandom_range(0, 9))) % 1024;
            fa = {idx[9:0], 2'b00};
            if ($urandom_range(0, 4) == 0) fa[1:0] = 2'($urandom_range(1, 3));
            cyc($urandom_range(0, 3) != 0, fa, 0, 32'h0, 0, 10'h0, 11'h0);
         end
      end

      idle(); idle();
      chk("queue_drained", q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
